char_ram_arbiter: RTL and testbench
===================================

CHAR_RAM_ARBITER -- requirements
Module: char_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, which is the character RAM address width (2048 cells).
REQ-002 The block SHALL have parameter DATA_W, default 8, which is the character cell data width.
REQ-003 The block SHALL have port clk, input, width 1: the single clock, which is the pixel clock.
REQ-004 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port disp_req, input, width 1: display read request from the text-mode fetch.
REQ-006 The block SHALL have port disp_addr, input, width ADDR_W: display read address.
REQ-007 The block SHALL have port disp_data, output, width DATA_W: display read data.
REQ-008 The block SHALL have port disp_valid, output, width 1: a pulse marking disp_data valid.
REQ-009 The block SHALL have port wb_cyc_i, input, width 1: Wishbone cycle.
REQ-010 The block SHALL have port wb_stb_i, input, width 1: Wishbone strobe.
REQ-011 The block SHALL have port wb_we_i, input, width 1: Wishbone write enable.
REQ-012 The block SHALL have port wb_adr_i, input, width ADDR_W: Wishbone cell address.
REQ-013 The block SHALL have port wb_dat_i, input, width DATA_W: Wishbone write data.
REQ-014 The block SHALL have port wb_dat_o, output, width DATA_W: Wishbone read data.
REQ-015 The block SHALL have port wb_ack_o, output, width 1: Wishbone acknowledge.
REQ-016 The block SHALL have port ram_en, output, width 1: single-port RAM access enable.
REQ-017 The block SHALL have port ram_we, output, width 1: RAM write enable.
REQ-018 The block SHALL have port ram_addr, output, width ADDR_W: RAM address.
REQ-019 The block SHALL have port ram_wdata, output, width DATA_W: RAM write data.
REQ-020 The block SHALL have port ram_rdata, input, width DATA_W: RAM read data, valid one cycle after an enabled read.
REQ-021 The block SHALL have port cnt_clr, input, width 1: clears the wait counter.
REQ-022 The block SHALL have port wb_wait_cnt, output, width 16: saturating count of cycles in which the Wishbone side was held off by the display.

Function
REQ-023 The block SHALL give the display absolute priority: whenever disp_req=1, the RAM port SHALL be driven in that same cycle with ram_en=1, ram_we=0 and ram_addr=disp_addr, and no Wishbone access SHALL be issued that cycle.
REQ-024 disp_valid SHALL be a registered copy of disp_req (latency 1), and disp_data SHALL equal ram_rdata in the cycle disp_valid=1.
REQ-025 The Wishbone FSM SHALL have the states IDLE, WAIT and ACK.
REQ-026 In IDLE, when wb_cyc_i&wb_stb_i=1 and disp_req=0, the block SHALL issue the access that cycle (ram_en=1, ram_we=wb_we_i, ram_addr=wb_adr_i, ram_wdata=wb_dat_i) and go to ACK.
REQ-027 In IDLE, when wb_cyc_i&wb_stb_i=1 and disp_req=1, the block SHALL go to WAIT.
REQ-028 In WAIT, if wb_cyc_i=0 the block SHALL return to IDLE with no RAM access and no ack.
REQ-029 In WAIT, if wb_cyc_i&wb_stb_i=1 and disp_req=0, the block SHALL issue the access exactly as in REQ-026 and go to ACK.
REQ-030 In WAIT, if disp_req=1 the block SHALL stay in WAIT.
REQ-031 In ACK, wb_ack_o SHALL be 1 for exactly that one cycle, and the block SHALL then go to IDLE unconditionally.
REQ-032 In ACK, wb_dat_o SHALL equal ram_rdata for reads; wb_dat_o SHALL be 0 outside ACK and for writes.
REQ-033 In ACK, no new Wishbone request SHALL be sampled, so each Wishbone access takes at least 2 cycles (request cycle plus ack cycle).
REQ-034 Each Wishbone access SHALL touch the RAM exactly once; there SHALL be no duplicate writes while the FSM waits.
REQ-035 When the FSM idles, ram_en, ram_we and ram_wdata SHALL be 0 and ram_addr SHALL hold its last value, unless display or Wishbone drives them.
REQ-036 wb_wait_cnt SHALL increment by 1 on each cycle in which the FSM is in WAIT (including the IDLE cycle that transitions to WAIT) and disp_req=1.
REQ-037 wb_wait_cnt SHALL saturate at 0xFFFF.
REQ-038 cnt_clr=1 SHALL set wb_wait_cnt to 0 on the next edge, taking priority over an increment that same cycle.
REQ-039 If wb_adr_i or wb_we_i changes while the FSM is in WAIT, the values present in the issue cycle SHALL be the ones used.

Reset
REQ-040 While rst=1, the FSM SHALL be forced to IDLE and wb_ack_o, wb_dat_o, disp_valid, disp_data, ram_en, ram_we, ram_wdata, ram_addr and wb_wait_cnt SHALL all be 0.
REQ-041 Asserting rst mid-WAIT or mid-ACK SHALL abort the transaction: no ack SHALL follow and no RAM write SHALL be issued after rst.

Verification
REQ-042 Scenario: Wishbone write of 0x41 to addr 0x005 with disp_req=0 -> in cycle N ram_we=1, ram_addr=0x005, ram_wdata=0x41; in N+1 wb_ack_o=1; a later read of 0x005 acks with wb_dat_o=0x41.
REQ-043 Scenario: disp_req held high for 5 cycles while a Wishbone read of 0x7FF is pending -> ram_addr follows disp_addr each cycle; the read is issued on the first cycle with disp_req=0, ack follows 1 cycle later; wb_wait_cnt=5.
REQ-044 Scenario: disp_req alternating 1/0 with back-to-back Wishbone writes -> every display read returns correct data with disp_valid 1 cycle after the request; every write is acked exactly once; RAM contents match the writes.
REQ-045 Scenario: a request enters WAIT, then wb_cyc_i drops while disp_req=1 -> FSM returns to IDLE, no RAM write, no ack.
REQ-046 Scenario: rst asserted in the WAIT state -> all outputs are 0 next cycle and no ack or write ever occurs for the aborted request.
REQ-047 Scenario: wb_wait_cnt forced to near saturation with long WAIT stalls -> it holds at 0xFFFF; cnt_clr together with a stall -> it reads 0.

Source files
------------

// File: rtl/char_ram_arbiter.sv
// rtl/char_ram_arbiter.sv - single-port character RAM arbiter, display reads over Wishbone
module char_ram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack_o,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              cnt_clr,
    output logic [15:0]       wb_wait_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              wb_req;
    logic              wb_issue;
    logic              wait_inc;
    logic              in_ack;
    logic              ack_we;
    logic              disp_valid_q;
    logic [15:0]       wait_cnt;
    logic [ADDR_W-1:0] last_addr;

    assign wb_req = wb_cyc_i & wb_stb_i;

    // The Wishbone access only reaches the RAM in a cycle the display leaves free.
    assign wb_issue = ~rst & ~disp_req & wb_req
                    & ((state == S_IDLE) | (state == S_WAIT));

    assign wait_inc = disp_req & (((state == S_IDLE) & wb_req) | (state == S_WAIT));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (wb_req) begin
                    state_next = disp_req ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i) begin
                    state_next = S_IDLE;
                end else if (wb_issue) begin
                    state_next = S_ACK;
                end
            end
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ack_we       <= 1'b0;
            disp_valid_q <= 1'b0;
            wait_cnt     <= 16'd0;
            last_addr    <= '0;
        end else begin
            state        <= state_next;
            disp_valid_q <= disp_req;
            if (wb_issue) begin
                ack_we <= wb_we_i;
            end
            if (cnt_clr) begin
                wait_cnt <= 16'd0;
            end else if (wait_inc && wait_cnt != 16'hFFFF) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (disp_req) begin
                last_addr <= disp_addr;
            end else if (wb_issue) begin
                last_addr <= wb_adr_i;
            end
        end
    end

    // The address bus parks on the last driven address to avoid needless toggling.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = last_addr;
        ram_wdata = '0;
        if (rst) begin
            ram_addr = '0;
        end else if (disp_req) begin
            ram_en   = 1'b1;
            ram_addr = disp_addr;
        end else if (wb_issue) begin
            ram_en   = 1'b1;
            ram_we   = wb_we_i;
            ram_addr = wb_adr_i;
            if (wb_we_i) begin
                ram_wdata = wb_dat_i;
            end
        end
    end

    assign in_ack      = ~rst & (state == S_ACK);
    assign wb_ack_o    = in_ack;
    assign wb_dat_o    = (in_ack & ~ack_we) ? ram_rdata : '0;
    assign disp_valid  = ~rst & disp_valid_q;
    assign disp_data   = disp_valid ? ram_rdata : '0;
    assign wb_wait_cnt = rst ? 16'd0 : wait_cnt;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// tb/tb_char_ram_arbiter.sv - vector table, saturation sequence and randomized model check
module tb_char_ram_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_we_i;
    logic [AW-1:0] wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_o;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = 8'h00;
    logic          cnt_clr;
    logic [15:0]   wb_wait_cnt;

    logic [DW-1:0] mem [0:2047] = '{default: 8'h00};
    logic [DW-1:0] shadow [0:2047];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    char_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .cnt_clr(cnt_clr), .wb_wait_cnt(wb_wait_cnt)
    );

    // Single-port RAM with one cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    typedef struct {
        logic          rst, dreq;
        logic [AW-1:0] dadr;
        logic          cyc, stb, we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic          clr;
        logic          e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_ack;
        logic [DW-1:0] e_wbdat;
        logic          e_dv;
        logic [DW-1:0] e_dd;
        logic [15:0]   e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic void add_vec(logic r, logic dq, logic [AW-1:0] da, logic c, logic s, logic w,
                                    logic [AW-1:0] a, logic [DW-1:0] d, logic cl,
                                    logic en, logic ewe, logic [AW-1:0] eaddr, logic [DW-1:0] ewd,
                                    logic ack, logic [DW-1:0] wbd, logic dv, logic [DW-1:0] dd,
                                    logic [15:0] cnt);
        vec_t t;
        t.rst = r; t.dreq = dq; t.dadr = da; t.cyc = c; t.stb = s; t.we = w; t.adr = a; t.dat = d;
        t.clr = cl; t.e_en = en; t.e_we = ewe; t.e_addr = eaddr; t.e_wdata = ewd; t.e_ack = ack;
        t.e_wbdat = wbd; t.e_dv = dv; t.e_dd = dd; t.e_cnt = cnt;
        vq.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic en, input logic we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic ack, input logic [DW-1:0] wbdat, input logic dv,
                              input logic [DW-1:0] dd, input logic [15:0] cnt);
        check({tag, " ram_en"},      ram_en,      en);
        check({tag, " ram_we"},      ram_we,      we);
        check({tag, " ram_addr"},    ram_addr,    addr);
        check({tag, " ram_wdata"},   ram_wdata,   wdata);
        check({tag, " wb_ack_o"},    wb_ack_o,    ack);
        check({tag, " wb_dat_o"},    wb_dat_o,    wbdat);
        check({tag, " disp_valid"},  disp_valid,  dv);
        check({tag, " disp_data"},   disp_data,   dd);
        check({tag, " wb_wait_cnt"}, wb_wait_cnt, cnt);
    endtask

    task automatic drive(input logic r, input logic dq, input logic [AW-1:0] da, input logic c,
                         input logic s, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic cl);
        rst = r; disp_req = dq; disp_addr = da; wb_cyc_i = c; wb_stb_i = s;
        wb_we_i = w; wb_adr_i = a; wb_dat_i = d; cnt_clr = cl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic          req_active, req_we, issued_prev, disp_prev, prev_we, issue, ack_now;
        logic [AW-1:0] req_adr, last_addr, da;
        logic [DW-1:0] req_dat, prev_read, prev_disp;
        logic          dq, cl;
        int            cnt_m;

        for (int i = 0; i < 2048; i++) shadow[i] = 8'h00;

        // rst dq dadr cyc stb we adr dat clr | en we addr wdata ack wbdat dv dd cnt
        add_vec(1,0,11'h000,0,0,0,11'h000,8'h00,0, 0,0,11'h000,8'h00,0,8'h00,0,8'h00,16'd0);
        add_vec(1,0,11'h000,0,0,0,11'h000,8'h00,0, 0,0,11'h000,8'h00,0,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,0,0,0,11'h000,8'h00,0, 0,0,11'h000,8'h00,0,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,1,1,1,11'h005,8'h41,0, 1,1,11'h005,8'h41,0,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,1,1,1,11'h005,8'h41,0, 0,0,11'h005,8'h00,1,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,0,0,0,11'h000,8'h00,0, 0,0,11'h005,8'h00,0,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,1,1,0,11'h005,8'h00,0, 1,0,11'h005,8'h00,0,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,1,1,0,11'h005,8'h00,0, 0,0,11'h005,8'h00,1,8'h41,0,8'h00,16'd0);
        add_vec(0,0,11'h000,0,0,0,11'h000,8'h00,0, 0,0,11'h005,8'h00,0,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,1,1,1,11'h7FF,8'h5A,0, 1,1,11'h7FF,8'h5A,0,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,1,1,1,11'h7FF,8'h5A,0, 0,0,11'h7FF,8'h00,1,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,0,0,0,11'h000,8'h00,0, 0,0,11'h7FF,8'h00,0,8'h00,0,8'h00,16'd0);
        // display stall of 5 cycles over a pending read of 0x7FF; address/we wiggle while waiting
        add_vec(0,1,11'h005,1,1,0,11'h7FF,8'h00,0, 1,0,11'h005,8'h00,0,8'h00,0,8'h00,16'd0);
        add_vec(0,1,11'h010,1,1,0,11'h7FF,8'h00,0, 1,0,11'h010,8'h00,0,8'h00,1,8'h41,16'd1);
        add_vec(0,1,11'h7FF,1,1,1,11'h123,8'hEE,0, 1,0,11'h7FF,8'h00,0,8'h00,1,8'h00,16'd2);
        add_vec(0,1,11'h011,1,1,0,11'h0AA,8'h00,0, 1,0,11'h011,8'h00,0,8'h00,1,8'h5A,16'd3);
        add_vec(0,1,11'h005,1,1,0,11'h7FF,8'h00,0, 1,0,11'h005,8'h00,0,8'h00,1,8'h00,16'd4);
        add_vec(0,0,11'h000,1,1,0,11'h7FF,8'h00,0, 1,0,11'h7FF,8'h00,0,8'h00,1,8'h41,16'd5);
        add_vec(0,0,11'h000,1,1,0,11'h7FF,8'h00,0, 0,0,11'h7FF,8'h00,1,8'h5A,0,8'h00,16'd5);
        add_vec(0,0,11'h000,0,0,0,11'h000,8'h00,0, 0,0,11'h7FF,8'h00,0,8'h00,0,8'h00,16'd5);
        // write parked in WAIT, then cyc drops while the display still owns the port
        add_vec(0,1,11'h020,1,1,1,11'h030,8'h77,0, 1,0,11'h020,8'h00,0,8'h00,0,8'h00,16'd5);
        add_vec(0,1,11'h021,1,1,1,11'h030,8'h77,0, 1,0,11'h021,8'h00,0,8'h00,1,8'h00,16'd6);
        add_vec(0,1,11'h022,0,0,0,11'h000,8'h00,0, 1,0,11'h022,8'h00,0,8'h00,1,8'h00,16'd7);
        add_vec(0,0,11'h000,0,0,0,11'h000,8'h00,0, 0,0,11'h022,8'h00,0,8'h00,1,8'h00,16'd8);
        add_vec(0,0,11'h000,1,1,0,11'h030,8'h00,0, 1,0,11'h030,8'h00,0,8'h00,0,8'h00,16'd8);
        add_vec(0,0,11'h000,1,1,0,11'h030,8'h00,0, 0,0,11'h030,8'h00,1,8'h00,0,8'h00,16'd8);
        add_vec(0,0,11'h000,0,0,0,11'h000,8'h00,0, 0,0,11'h030,8'h00,0,8'h00,0,8'h00,16'd8);
        // reset while a write waits in WAIT
        add_vec(0,1,11'h005,1,1,1,11'h040,8'h99,0, 1,0,11'h005,8'h00,0,8'h00,0,8'h00,16'd8);
        add_vec(1,1,11'h006,1,1,1,11'h040,8'h99,0, 0,0,11'h000,8'h00,0,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,0,0,0,11'h000,8'h00,0, 0,0,11'h000,8'h00,0,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,1,1,0,11'h040,8'h00,0, 1,0,11'h040,8'h00,0,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,1,1,0,11'h040,8'h00,0, 0,0,11'h040,8'h00,1,8'h00,0,8'h00,16'd0);
        add_vec(0,0,11'h000,0,0,0,11'h000,8'h00,0, 0,0,11'h040,8'h00,0,8'h00,0,8'h00,16'd0);

        drive(1,0,'0,0,0,0,'0,'0,0);
        step();
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].dreq, vq[i].dadr, vq[i].cyc, vq[i].stb, vq[i].we,
                  vq[i].adr, vq[i].dat, vq[i].clr);
            #4;
            check_outs($sformatf("vec%0d", i), vq[i].e_en, vq[i].e_we, vq[i].e_addr, vq[i].e_wdata,
                       vq[i].e_ack, vq[i].e_wbdat, vq[i].e_dv, vq[i].e_dd, vq[i].e_cnt);
            step();
        end
        shadow[11'h005] = 8'h41;
        shadow[11'h7FF] = 8'h5A;

        // Long stall drives the wait counter into saturation, then clear during the stall.
        for (int k = 0; k < 65540; k++) begin
            drive(0,1,11'h123,1,1,0,11'h7FF,8'h00,0);
            #4;
            if (k == 65534) check("sat pre", wb_wait_cnt, 16'hFFFE);
            if (k == 65535) check("sat hit", wb_wait_cnt, 16'hFFFF);
            if (k == 65539) check("sat hold", wb_wait_cnt, 16'hFFFF);
            if (k == 1000)  check("stall no ack", wb_ack_o, 1'b0);
            step();
        end
        drive(0,1,11'h123,1,1,0,11'h7FF,8'h00,1);
        #4;
        check("clr cycle", wb_wait_cnt, 16'hFFFF);
        step();
        drive(0,1,11'h123,1,1,0,11'h7FF,8'h00,0);
        #4;
        check("after clr", wb_wait_cnt, 16'h0000);
        step();
        drive(0,0,11'h000,1,1,0,11'h7FF,8'h00,0);
        #4;
        check_outs("stall issue", 1'b1, 1'b0, 11'h7FF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 16'd1);
        step();
        #4;
        check_outs("stall ack", 1'b0, 1'b0, 11'h7FF, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h00, 16'd1);
        step();
        drive(0,0,11'h000,0,0,0,11'h000,8'h00,0);
        step();

        // Random traffic against a transaction-level model.
        req_active = 0; req_we = 0; req_adr = '0; req_dat = '0;
        issued_prev = 0; disp_prev = 0; prev_we = 0; prev_read = '0; prev_disp = '0;
        last_addr = 11'h7FF; cnt_m = 1;
        for (int n = 0; n < 3000; n++) begin
            if (!req_active && $urandom_range(0, 2) != 0) begin
                req_active = 1'b1;
                req_we     = 1'($urandom_range(0, 1));
                req_adr    = ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom_range(0, 63));
                req_dat    = 8'($urandom_range(0, 255));
            end
            dq = 1'($urandom_range(0, 1));
            da = 11'($urandom_range(0, 63));
            cl = ($urandom_range(0, 63) == 0);
            if (req_active)
                drive(0, dq, da, 1'b1, 1'b1, req_we, req_adr, req_dat, cl);
            else
                drive(0, dq, da, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 63)),
                      8'($urandom_range(0, 255)), cl);
            ack_now = issued_prev;
            issue   = req_active & ~dq & ~ack_now;
            #4;
            check_outs($sformatf("rnd%0d", n), dq | issue, issue & req_we,
                       dq ? da : (issue ? req_adr : last_addr),
                       (issue & req_we) ? req_dat : 8'h00,
                       ack_now, (ack_now & ~prev_we) ? prev_read : 8'h00,
                       disp_prev, disp_prev ? prev_disp : 8'h00, 16'(cnt_m));
            if (cl) cnt_m = 0;
            else if (req_active && dq && !ack_now && cnt_m < 65535) cnt_m++;
            if (dq) begin
                prev_disp = shadow[da];
                last_addr = da;
            end else if (issue) begin
                last_addr = req_adr;
            end
            if (issue) begin
                prev_we = req_we;
                if (req_we) shadow[req_adr] = req_dat;
                else        prev_read = shadow[req_adr];
            end
            if (ack_now) req_active = 1'b0;
            disp_prev   = dq;
            issued_prev = issue;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
